// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and S-box lookup.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_KEY_W      = 128;
    localparam int AES_NUM_ROUNDS = 10;
    localparam int ROUND_KEYS_W   = AES_KEY_W * (AES_NUM_ROUNDS + 1);

    // Round constants, indexed by round number 1..10.
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } kx_state_t;

    // Forward S-box, entry 0 is the leftmost element.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Rounds outside 1..10 have no constant; they only occur on an
    // illegal counter value, which the FSM discards anyway.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        if (r >= 4'd1 && r <= 4'd10) begin
            v = RCON[r];
        end
        return v;
    endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
// Latency: combinational. Backpressure: none.
// Ports: i_word (32b in), o_word (32b substituted out).
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock into a flat 1408-bit bus.
// Latency: 10 cycles from accepted start to keys_valid.
// Backpressure: start is ignored while busy; no queueing.
// Ports: clk, reset (async, active-high), start, key_in[127:0] in;
//        busy, keys_valid, round_keys[1407:0] out (all registered).
module key_expansion
    import aes_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AES_KEY_W-1:0]    key_in,
    output logic                    busy,
    output logic                    keys_valid,
    output logic [ROUND_KEYS_W-1:0] round_keys
);

    kx_state_t                r_state;
    logic [3:0]               r_cnt;
    logic [AES_KEY_W-1:0]     r_prev;
    logic [ROUND_KEYS_W-1:0]  r_round_keys;
    logic                     r_busy;
    logic                     r_keys_valid;

    kx_state_t                w_state_nxt;
    logic [3:0]               w_cnt_nxt;
    logic                     w_load;
    logic                     w_write;
    logic [31:0]              w_rot;
    logic [31:0]              w_sub;
    logic [31:0]              w_temp;
    logic [31:0]              w_n0, w_n1, w_n2, w_n3;
    logic [AES_KEY_W-1:0]     w_next_key;

    // One expansion round from the previous round key.
    assign w_rot = {r_prev[23:0], r_prev[31:24]};

    sub_word u_sub_word (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    assign w_temp     = w_sub ^ {rcon_of(r_cnt), 24'h000000};
    assign w_n0       = r_prev[127:96] ^ w_temp;
    assign w_n1       = w_n0 ^ r_prev[95:64];
    assign w_n2       = w_n1 ^ r_prev[63:32];
    assign w_n3       = w_n2 ^ r_prev[31:0];
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                if (r_cnt >= 4'd1 && r_cnt <= 4'd10) begin
                    w_write = 1'b1;
                    if (r_cnt == 4'd10) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end else begin
                    // Unreachable counter value: abandon the schedule.
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            // Flags are registered from the next state so they line up
            // with the state register and never depend on inputs directly.
            r_busy       <= (w_state_nxt == EXPAND);
            r_keys_valid <= (w_state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev       <= '0;
            r_round_keys <= '0;
        end else if (w_load) begin
            r_prev <= key_in;
            r_round_keys[ROUND_KEYS_W-1 -: AES_KEY_W] <= key_in;
        end else if (w_write) begin
            r_prev <= w_next_key;
            for (int i = 1; i <= AES_NUM_ROUNDS; i++) begin
                if (r_cnt == i[3:0]) begin
                    r_round_keys[ROUND_KEYS_W-1-AES_KEY_W*i -: AES_KEY_W] <= w_next_key;
                end
            end
        end
    end

    assign busy       = r_busy;
    assign keys_valid = r_keys_valid;
    assign round_keys = r_round_keys;

endmodule

// File: doc/key_expansion.md
# key_expansion

Iterative AES-128 key schedule that sits directly upstream of the encryption datapath. It takes a 128-bit cipher key and produces all 11 round keys, one round key per clock after the initial load. It presents them as a single 1408-bit flat bus with a level valid flag, which the encryption block consumes unchanged.

## Interface
- Parameters: none. AES-128 only; the 128-bit key and 10 rounds are fixed.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  single-cycle request to expand `key_in`; honoured only when `busy` is 0.
- key_in  input  128  cipher key; sampled only on the accepted `start` edge; bits [127:96] are word w0.
- busy  output  1  high while expansion is in progress.
- keys_valid  output  1  high when `round_keys` holds a complete schedule for the last accepted key.
- round_keys  output  1408  round key i occupies [1407-128*i -: 128], for i = 0..10; round 0 is the cipher key.

## Operation
- FSM states:
  - IDLE (after reset, `keys_valid`=0).
  - EXPAND.
  - DONE (`keys_valid`=1).
- IDLE/DONE + `start`: latch `key_in` into round slot 0, round counter := 1, `keys_valid` := 0, go to EXPAND.
- EXPAND: each cycle, compute round key r from round key r-1 and write slot r.
  - w = previous words w0..w3.
  - temp = SubWord(RotWord(w3)) ^ {RCON[r], 24'h0}.
  - n0 = w0^temp, n1 = n0^w1, n2 = n1^w2, n3 = n2^w3.
- EXPAND with r = 10: write slot 10, go to DONE, `keys_valid` := 1.
- RCON[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- RotWord rotates left by one byte. SubWord applies the AES S-box to each byte.
- `start` while `busy`=1 is ignored; no queueing and no error flag.
- `start` in DONE restarts expansion.
  - `keys_valid` falls on the accepting edge.
  - Slots 1..10 keep stale contents until overwritten; consumers must gate on `keys_valid`.
- Counter width is 4 bits; values 11..15 are unreachable. If reached, treat as IDLE.

## Timing
- Reset values: `busy`=0, `keys_valid`=0, `round_keys`=0, FSM=IDLE, counter=0.
- `start` accepted at edge T:
  - Slot 0 is valid after edge T.
  - Slot r is written at edge T+r.
  - `busy` is high from after edge T through edge T+10.
  - At edge T+10, `busy` falls and `keys_valid` rises.
- Total latency from accepting edge to valid is 10 cycles. `busy` and `keys_valid` are never high together.
- Back-to-back: `start` sampled in the same cycle that `keys_valid` first reads 1 is accepted.
- Reset asserted mid-EXPAND: all outputs return to reset values immediately (asynchronous). No partial schedule remains visible.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `aes_pkg`:
  - `AES_KEY_W`=128 and `AES_NUM_ROUNDS`=10.
  - `ROUND_KEYS_W`=1408.
  - RCON constant array.
  - FSM state enum {IDLE, EXPAND, DONE}.
  - S-box lookup function, shared with `sub_bytes`.
- One sub-module, `sub_word`: combinational 32-bit SubWord made of four S-box lookups, instantiated once.
- Datapath: one 128-bit "previous key" register feeding a single expansion round, plus the 1408-bit output register written by slot index.

## Test plan
- FIPS-197 A.1 key: drive `key_in` = 2b7e151628aed2a6abf7158809cf4f3c with `start` for one cycle.
  - `keys_valid` rises 10 cycles later.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Round 0 = the key.
- All-zero key:
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- `start` pulsed again at cycles T+3 and T+7 with a different `key_in`: both ignored; the final schedule matches the first key; `busy` stays high for exactly 10 cycles.
- Restart from DONE with the zero key after the A.1 run: `keys_valid` drops the next cycle, then returns after 10 cycles with the zero-key schedule.
- Assert `reset` at T+5:
  - `busy`, `keys_valid` and `round_keys` are all 0 immediately and stay 0 after release.
  - A new `start` then yields the correct A.1 schedule.
- Random-key sweep (≥200 keys) against a reference model: every round key matches, and latency is always 10 cycles.
